mem_port_arbiter: RTL and testbench

Two-port access controller for the 256x8 byte-addressed RAM. It arbitrates between the instruction-fetch port and the data (load/store) port, sequences the RAM's MOV/MOC handshake, and registers read data and completion status back to the winning requester. A MOC watchdog bounds every access. The block sits between the CPU control unit and the RAM; it is the only driver of the RAM's MOV, ReadWrite, MS_2_0, Address and DataIn.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-port (fetch/data) arbiter and MOV/MOC sequencer for the
//            256x8 RAM, with a MOC watchdog and registered completion status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        CLR,
    // instruction-fetch port
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic        IDone,
    output logic [31:0] IData,
    // data (load/store) port
    input  logic        DReq,
    input  logic        DRW,
    input  logic [2:0]  DMS,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic        DDone,
    output logic [31:0] DRData,
    // status
    output logic        Err,
    output logic        Busy,
    // RAM side
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    input  logic        MOC,
    input  logic [31:0] DataOut
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] C_MS_WORD  = 3'b010;

    state_t      r_state;
    logic        r_gnt_data;   // 1 = data port owns the current access
    logic        r_prio_data;  // 1 = data port wins the next contention
    logic [7:0]  r_cnt;

    logic        w_any_req;
    logic        w_both_req;
    logic        w_grant_data;

    assign w_any_req    = IReq | DReq;
    assign w_both_req   = IReq & DReq;
    assign w_grant_data = DReq & (~IReq | r_prio_data);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state     <= ST_IDLE;
            r_gnt_data  <= 1'b0;
            r_prio_data <= 1'b1;
            r_cnt       <= 8'd0;
            MOV         <= 1'b0;
            ReadWrite   <= 1'b1;
            MS_2_0      <= 3'b000;
            Address     <= 32'd0;
            DataIn      <= 32'd0;
            IDone       <= 1'b0;
            DDone       <= 1'b0;
            Err         <= 1'b0;
            Busy        <= 1'b0;
            IData       <= 32'd0;
            DRData      <= 32'd0;
        end else begin
            IDone <= 1'b0;
            DDone <= 1'b0;
            Err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    MOV <= 1'b0;
                    if (w_any_req) begin
                        r_gnt_data <= w_grant_data;
                        if (w_both_req) begin
                            r_prio_data <= ~r_prio_data;
                        end
                        if (w_grant_data) begin
                            Address   <= DAddr;
                            ReadWrite <= DRW;
                            MS_2_0    <= DMS;
                            DataIn    <= DWData;
                        end else begin
                            Address   <= IAddr;
                            ReadWrite <= 1'b1;
                            MS_2_0    <= C_MS_WORD;
                            DataIn    <= 32'd0;
                        end
                        Busy    <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end

                // Address/control were loaded last edge; MOV follows one cycle later
                ST_ISSUE: begin
                    MOV     <= 1'b1;
                    r_cnt   <= 8'd0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (MOC) begin
                        if (ReadWrite) begin
                            if (r_gnt_data) begin
                                DRData <= DataOut;
                            end else begin
                                IData  <= DataOut;
                            end
                        end
                        IDone   <= ~r_gnt_data;
                        DDone   <= r_gnt_data;
                        MOV     <= 1'b0;
                        r_state <= ST_RELEASE;
                    end else if (r_cnt == C_TMO_LAST) begin
                        IDone   <= ~r_gnt_data;
                        DDone   <= r_gnt_data;
                        Err     <= 1'b1;
                        MOV     <= 1'b0;
                        r_state <= ST_RELEASE;
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                // Hold off the next grant until the RAM has dropped MOC
                ST_RELEASE: begin
                    MOV <= 1'b0;
                    if (!MOC) begin
                        Busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    MOV     <= 1'b0;
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a behavioural RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        CLK;
    logic        CLR;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IDone;
    logic [31:0] IData;
    logic        DReq;
    logic        DRW;
    logic [2:0]  DMS;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic        DDone;
    logic [31:0] DRData;
    logic        Err;
    logic        Busy;
    logic        MOV;
    logic        ReadWrite;
    logic [2:0]  MS_2_0;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        MOC;
    logic [31:0] DataOut;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .CLR(CLR),
        .IReq(IReq), .IAddr(IAddr), .IDone(IDone), .IData(IData),
        .DReq(DReq), .DRW(DRW), .DMS(DMS), .DAddr(DAddr), .DWData(DWData),
        .DDone(DDone), .DRData(DRData),
        .Err(Err), .Busy(Busy),
        .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0), .Address(Address),
        .DataIn(DataIn), .MOC(MOC), .DataOut(DataOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        port;   // 1 = data port
        logic        err;
        logic        rw;
        logic [2:0]  ms;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;  // expected IData/DRData after Done
        int          lat;    // grant edge to Done edge
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Behavioural RAM: raises MOC moc_delay cycles after MOV, holds it moc_hold cycles
    logic        ram_en;
    int          moc_delay;
    int          moc_hold;
    logic        use_fixed;
    logic [31:0] fixed_word;
    int          wait_cnt;
    int          hold_cnt;

    always @(negedge CLK) begin
        if (!CLR) begin
            MOC      = 1'b0;
            wait_cnt = 0;
            hold_cnt = 0;
        end else if (hold_cnt > 0) begin
            hold_cnt = hold_cnt - 1;
            if (hold_cnt == 0) MOC = 1'b0;
        end else if (MOV && ram_en) begin
            if (wait_cnt >= moc_delay - 1) begin
                MOC      = 1'b1;
                DataOut  = use_fixed ? fixed_word : {24'h00C0DE, Address[7:0]};
                hold_cnt = moc_hold;
                wait_cnt = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: checks RAM-side control at MOV rise and completion at Done
    logic        prev_mov  = 1'b0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          cyc = 0;

    always @(negedge CLK) begin
        if (CLR) begin
            if (Busy) cyc = prev_busy ? cyc + 1 : 0;
            if (MOV && !prev_mov) begin
                if (sb.size() == 0) begin
                    timeout_fail("issue_without_expected");
                end else begin
                    check("issue_addr_before_mov", prev_addr, sb[0].addr);
                    check("issue_addr", Address, sb[0].addr);
                    check("issue_rw", {31'd0, ReadWrite}, {31'd0, sb[0].rw});
                    check("issue_ms", {29'd0, MS_2_0}, {29'd0, sb[0].ms});
                    check("issue_datain", DataIn, sb[0].din);
                end
            end
            if (IDone || DDone) begin
                check("single_done", {31'd0, IDone & DDone}, 32'd0);
                if (sb.size() == 0) begin
                    timeout_fail("unexpected_done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_port", {31'd0, DDone}, {31'd0, e.port});
                    check("done_err", {31'd0, Err}, {31'd0, e.err});
                    check("done_latency", cyc, e.lat);
                    check("done_rdata", e.port ? DRData : IData, e.rdata);
                end
            end else if (Err) begin
                timeout_fail("err_without_done");
            end
        end
        prev_mov  = MOV;
        prev_busy = Busy;
        prev_addr = Address;
    end

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        exp_t e;
        e = '{port: 1'b0, err: 1'b0, rw: 1'b1, ms: 3'b010, addr: addr, din: 32'd0,
              rdata: rdata, lat: 3};
        sb.push_back(e);
    endtask

    task automatic push_data(input logic rw, input logic [2:0] ms, input logic [31:0] addr,
                             input logic [31:0] wd, input logic err, input logic [31:0] rdata,
                             input int lat);
        exp_t e;
        e = '{port: 1'b1, err: err, rw: rw, ms: ms, addr: addr, din: wd,
              rdata: rdata, lat: lat};
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (IDone || DDone) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout_fail(name);
    endtask

    initial begin
        int gap;
        CLR = 1'b0; IReq = 1'b0; DReq = 1'b0; IAddr = 32'd0; DRW = 1'b1; DMS = 3'd0;
        DAddr = 32'd0; DWData = 32'd0; MOC = 1'b0; DataOut = 32'd0;
        ram_en = 1'b1; moc_delay = 2; moc_hold = 1; use_fixed = 1'b0; fixed_word = 32'd0;
        wait_cnt = 0; hold_cnt = 0;

        // Contention: both ports requesting from reset
        IReq = 1'b1; IAddr = 32'h40;
        DReq = 1'b1; DRW = 1'b1; DMS = 3'b101; DAddr = 32'h30; DWData = 32'h77;
        repeat (3) @(negedge CLK);
        check("rst_mov", {31'd0, MOV}, 32'd0);
        check("rst_rw", {31'd0, ReadWrite}, 32'd1);
        check("rst_ms", {29'd0, MS_2_0}, 32'd0);
        check("rst_addr", Address, 32'd0);
        check("rst_datain", DataIn, 32'd0);
        check("rst_idone", {31'd0, IDone}, 32'd0);
        check("rst_ddone", {31'd0, DDone}, 32'd0);
        check("rst_err", {31'd0, Err}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_idata", IData, 32'd0);
        check("rst_drdata", DRData, 32'd0);

        push_data(1'b1, 3'b101, 32'h30, 32'h77, 1'b0, 32'h00C0DE30, 3);
        push_fetch(32'h40, 32'h00C0DE40);
        push_data(1'b1, 3'b101, 32'h30, 32'h77, 1'b0, 32'h00C0DE30, 3);
        push_fetch(32'h40, 32'h00C0DE40);
        CLR = 1'b1;
        for (int k = 0; k < 4; k++) wait_done("contention_done");
        IReq = 1'b0; DReq = 1'b0;
        repeat (3) @(negedge CLK);

        // Single fetch
        use_fixed = 1'b1; fixed_word = 32'hDEADBEEF;
        push_fetch(32'h10, 32'hDEADBEEF);
        IReq = 1'b1; IAddr = 32'h10;
        wait_done("fetch_done");
        IReq = 1'b0; use_fixed = 1'b0;
        @(negedge CLK);
        check("fetch_busy_fall", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge CLK);

        // Store: DRData keeps the last load value
        push_data(1'b0, 3'b000, 32'h20, 32'hA5, 1'b0, 32'h00C0DE30, 3);
        DReq = 1'b1; DRW = 1'b0; DMS = 3'b000; DAddr = 32'h20; DWData = 32'hA5;
        wait_done("store_done");
        DReq = 1'b0;
        repeat (3) @(negedge CLK);

        // Timeout with MOC stuck low
        ram_en = 1'b0;
        push_data(1'b1, 3'b010, 32'h50, 32'h0, 1'b1, 32'h00C0DE30, 5);
        DReq = 1'b1; DRW = 1'b1; DMS = 3'b010; DAddr = 32'h50; DWData = 32'h0;
        wait_done("timeout_done");
        DReq = 1'b0;
        check("timeout_mov_low", {31'd0, MOV}, 32'd0);
        @(negedge CLK);
        check("timeout_idle", {31'd0, Busy}, 32'd0);
        ram_en = 1'b1;
        repeat (2) @(negedge CLK);

        // Stale MOC: held 3 cycles past MOV fall, next fetch queued behind it
        moc_hold = 4;
        push_fetch(32'h60, 32'h00C0DE60);
        push_fetch(32'h60, 32'h00C0DE60);
        IReq = 1'b1; IAddr = 32'h60;
        wait_done("stale_done1");
        moc_hold = 1;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            gap++;
            if (MOV) break;
        end
        check("stale_regrant_gap", gap, 6);
        wait_done("stale_done2");
        IReq = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset in the middle of a WAIT
        ram_en = 1'b0;
        push_data(1'b0, 3'b001, 32'h70, 32'h55, 1'b0, 32'h00C0DE30, 3);
        DReq = 1'b1; DRW = 1'b0; DMS = 3'b001; DAddr = 32'h70; DWData = 32'h55;
        for (int i = 0; i < 10 && !MOV; i++) @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        #1;
        check("midrst_mov", {31'd0, MOV}, 32'd0);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_drdata", DRData, 32'd0);
        sb.delete();
        DReq = 1'b0;
        repeat (3) @(negedge CLK);
        CLR = 1'b1;
        ram_en = 1'b1;
        @(negedge CLK);
        push_fetch(32'h10, 32'h00C0DE10);
        IReq = 1'b1; IAddr = 32'h10;
        wait_done("post_reset_fetch");
        IReq = 1'b0;
        repeat (4) @(negedge CLK);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
